// File: rtl/mem_arbiter.sv
// Two-port arbiter between instruction and data caches and a single-ported RAM.
// Data has priority; instruction fetches get a bounded-starvation grant.
module mem_arbiter #(
   parameter int unsigned MAX_DSTREAK = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_e;
   typedef enum logic [1:0] {R_FREE, R_BUSY, R_ACCESS, R_ERROR} ramstate_e;

   localparam logic [3:0] MAX4 = 4'(MAX_DSTREAK);

   state_e      state_q;
   logic [3:0]  dstreak_q;
   logic [7:0]  err_q;
   logic [31:0] addr_q;
   logic [31:0] store_q;
   logic        wen_q;
   ramstate_e   rs;

   assign rs = ramstate_e'(ramstate);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         dstreak_q <= '0;
         err_q     <= '0;
         addr_q    <= '0;
         store_q   <= '0;
         wen_q     <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // Starvation guard outranks the normal data-first priority.
               if (iREN && (dstreak_q == MAX4)) begin
                  state_q   <= IBUSY;
                  addr_q    <= iaddr;
                  wen_q     <= 1'b0;
                  dstreak_q <= '0;
               end else if (dREN || dWEN) begin
                  state_q <= DBUSY;
                  addr_q  <= daddr;
                  store_q <= dstore;
                  wen_q   <= dWEN;
                  if (iREN && (dstreak_q != MAX4))
                     dstreak_q <= dstreak_q + 4'd1;
               end else if (iREN) begin
                  state_q   <= IBUSY;
                  addr_q    <= iaddr;
                  wen_q     <= 1'b0;
                  dstreak_q <= '0;
               end
            end
            IBUSY, DBUSY: begin
               if (rs == R_ACCESS) begin
                  state_q <= IDLE;
               end else if (rs == R_ERROR) begin
                  state_q <= IDLE;
                  if (err_q != '1)
                     err_q <= err_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic busy;
   assign busy      = (state_q != IDLE);
   assign ramREN    = busy & ~wen_q;
   assign ramWEN    = busy & wen_q;
   assign ramaddr   = addr_q;
   assign ramstore  = store_q;
   assign err_count = err_q;

   assign iload = ramload;
   assign dload = ramload;
   assign iwait = ~((state_q == IBUSY) && (rs == R_ACCESS));
   assign dwait = ~((state_q == DBUSY) && (rs == R_ACCESS));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model compared
// every cycle, plus literal expectations for the documented scenarios.
module tb_mem_arbiter;

   localparam int MAXD = 4;

   logic        CLK, nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.MAX_DSTREAK(MAXD)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .err_count(err_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: who owns the RAM (0 none, 1 instr, 2 data) and what was captured.
   int          m_owner;
   logic [31:0] m_addr, m_store;
   bit          m_write;
   int          m_streak, m_errs;
   string       m_log, dut_log;

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_owner = 0; m_addr = 0; m_store = 0; m_write = 0;
         m_streak = 0; m_errs = 0;
      end else if (m_owner == 0) begin
         if (iREN && m_streak == MAXD || iREN && !(dREN || dWEN)) begin
            m_owner = 1; m_addr = iaddr; m_write = 0; m_streak = 0;
            m_log = {m_log, "I"};
         end else if (dREN || dWEN) begin
            m_owner = 2; m_addr = daddr; m_store = dstore; m_write = dWEN;
            if (iREN) m_streak = (m_streak + 1 > MAXD) ? MAXD : m_streak + 1;
            m_log = {m_log, "D"};
         end
      end else if (ramstate == 2) begin
         m_owner = 0;
      end else if (ramstate == 3) begin
         m_owner = 0;
         m_errs = (m_errs == 255) ? 255 : m_errs + 1;
      end
   end

   always @(negedge CLK) begin
      chk("ramREN",   ramREN,   (m_owner != 0) && !m_write);
      chk("ramWEN",   ramWEN,   (m_owner != 0) && m_write);
      chk("ramaddr",  ramaddr,  m_addr);
      chk("ramstore", ramstore, m_store);
      chk("iwait",    iwait,    !(m_owner == 1 && ramstate == 2));
      chk("dwait",    dwait,    !(m_owner == 2 && ramstate == 2));
      chk("err_count", err_count, m_errs);
      if (!iwait) chk("iload", iload, ramload);
      if (!dwait) chk("dload", dload, ramload);
      if (!dwait) dut_log = {dut_log, "D"};
      if (!iwait) dut_log = {dut_log, "I"};
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   initial begin
      nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 0;
      step(); step();
      #4;
      chk("rst_ramREN", ramREN, 0);
      chk("rst_ramWEN", ramWEN, 0);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_iwait", iwait, 1);
      chk("rst_dwait", dwait, 1);
      chk("rst_err", err_count, 0);
      nRST = 1;

      // single instruction read completing on first busy cycle
      step(); iREN = 1; iaddr = 32'h40;
      step(); iREN = 0; ramstate = 2; ramload = 32'hDEADBEEF;
      #4;
      chk("t1_ramREN", ramREN, 1);
      chk("t1_ramaddr", ramaddr, 32'h40);
      chk("t1_iwait", iwait, 0);
      chk("t1_iload", iload, 32'hDEADBEEF);
      step(); ramstate = 0;
      #4;
      chk("t1_idle_ren", ramREN, 0);
      chk("t1_idle_iwait", iwait, 1);

      // write wins over read; bus changes after grant must not leak through
      step(); dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
      step(); dREN = 0; dWEN = 0; daddr = 0; dstore = 0; ramstate = 1;
      for (int i = 0; i < 2; i++) begin
         #4;
         chk("t2_ramWEN", ramWEN, 1);
         chk("t2_ramREN", ramREN, 0);
         chk("t2_ramaddr", ramaddr, 32'h80);
         chk("t2_ramstore", ramstore, 32'h1234);
         chk("t2_dwait_busy", dwait, 1);
         step(); ramstate = (i == 0) ? 2'd1 : 2'd2;
      end
      #4;
      chk("t2_dwait_acc", dwait, 0);
      chk("t2_ramstore_acc", ramstore, 32'h1234);
      step(); ramstate = 0;
      #4;
      chk("t2_idle_wen", ramWEN, 0);
      chk("t2_hold_addr", ramaddr, 32'h80);

      // ERROR then retry
      step(); dREN = 1; daddr = 32'h100;
      step(); ramstate = 3;
      #4;
      chk("t4_iwait_err", iwait, 1);
      chk("t4_dwait_err", dwait, 1);
      chk("t4_ren_err", ramREN, 1);
      step(); ramstate = 0;
      #4;
      chk("t4_idle_ren", ramREN, 0);
      chk("t4_err1", err_count, 1);
      step(); ramstate = 2; ramload = 32'hCAFEF00D; dREN = 0;
      #4;
      chk("t4_retry_dwait", dwait, 0);
      chk("t4_retry_dload", dload, 32'hCAFEF00D);
      step(); ramstate = 0;

      // asynchronous reset during a write
      step(); dWEN = 1; daddr = 32'h200; dstore = 32'h55;
      step(); dWEN = 0; ramstate = 1;
      #4;
      chk("t5_wen_before", ramWEN, 1);
      #1; ramstate = 2; nRST = 0;
      #1;
      chk("t5_wen_rst", ramWEN, 0);
      chk("t5_dwait_rst", dwait, 1);
      chk("t5_err_rst", err_count, 0);
      chk("t5_addr_rst", ramaddr, 0);
      step(); nRST = 1; ramstate = 0;
      step(); iREN = 1; iaddr = 32'h44;
      step(); iREN = 0; ramstate = 2;
      #4;
      chk("t5_iwait", iwait, 0);
      chk("t5_ramaddr", ramaddr, 32'h44);
      step(); ramstate = 0;

      // fairness: both held, every access completes immediately
      step(); iREN = 1; dREN = 1; ramstate = 2; m_log = ""; dut_log = "";
      repeat (20) step();
      iREN = 0; dREN = 0; ramstate = 0;
      step(); step();
      checks++;
      if (dut_log != "DDDDIDDDDI") begin
         errors++;
         $display("FAIL grant_order: got %s expected DDDDIDDDDI", dut_log);
      end
      checks++;
      if (m_log != "DDDDIDDDDI") begin
         errors++;
         $display("FAIL model_order: got %s expected DDDDIDDDDI", m_log);
      end

      // error counter saturation
      step(); dREN = 1; ramstate = 3;
      repeat (250) step();
      chk("t6_err125", err_count, 125);
      repeat (370) step();
      chk("t6_err_sat", err_count, 255);
      dREN = 0; ramstate = 0;
      step(); step();
      chk("t6_err_hold", err_count, 255);
      chk("t6_model_sat", m_errs, 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter between the instruction cache and the data cache on one side and the single-ported RAM on the other. Each cycle it either idles or services exactly one cache transaction. Data requests have priority, with a bounded-starvation guarantee for instruction fetches. Address, store data and direction are latched at grant, so a requester's bus may change mid-transaction without corrupting the RAM access.

## Interface
Parameters:
- MAX_DSTREAK, 4: max consecutive data grants issued while an instruction request is pending; range 1..15.

Ports:
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  asynchronous, active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- iload  out  32  instruction read data
- iwait  out  1  low for exactly the completion cycle of an instruction access
- dREN  in  1  data read request
- dWEN  in  1  data write request; wins if dREN also high
- daddr  in  32  data address
- dstore  in  32  data write value
- dload  out  32  data read data
- dwait  out  1  low for exactly the completion cycle of a data access
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address (latched)
- ramstore  out  32  RAM write data (latched)
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- err_count  out  8  saturating count of ERROR responses

## Operation
- FSM states: IDLE, IBUSY, DBUSY. Reset enters IDLE.
- IDLE arbitration, evaluated in priority order:
  1. iREN=1 and dstreak==MAX_DSTREAK: go to IBUSY.
  2. dREN|dWEN=1: go to DBUSY.
  3. iREN=1: go to IBUSY.
  4. Otherwise stay in IDLE.
- At grant, latch the address, store data and op into registers:
  - I grant: read, iaddr.
  - D grant: write if dWEN=1, else read; daddr and dstore.
- dstreak (4-bit):
  - On a D grant with iREN=1: increment, saturating at MAX_DSTREAK.
  - On any I grant: clear to 0.
  - On a D grant with iREN=0: hold.
- In IBUSY/DBUSY:
  - Drive ramREN/ramWEN from the latched op; ramaddr/ramstore come from the latches.
  - In IDLE, ramREN=ramWEN=0 and ramaddr/ramstore hold their last latched values.
- Completion is ramstate==ACCESS while busy:
  - The matching wait output goes low that cycle.
  - Next state is IDLE.
- ERROR while busy:
  - The wait output stays high.
  - Next state is IDLE and the request is re-arbitrated.
  - err_count increments, saturating at 255.
- FREE or BUSY while busy: stay in the current state.
- Requester drops its request mid-transaction: the access still completes. Its wait-low pulse is issued and the requester may ignore it.
- iload=ramload and dload=ramload (combinational pass-through). Values are meaningful only during the corresponding completion cycle.
- iwait=~(state==IBUSY & ramstate==ACCESS); dwait=~(state==DBUSY & ramstate==ACCESS).

## Timing
- Reset values:
  - state=IDLE, dstreak=0, err_count=0.
  - Latches cleared to 0, so ramaddr=0 and ramstore=0.
  - ramREN=0, ramWEN=0, iwait=1, dwait=1.
- Minimum latency:
  - Request seen in IDLE at cycle 0; RAM strobe asserted in cycle 1.
  - If ramstate==ACCESS in cycle 1, wait is low in cycle 1.
  - Minimum request-to-completion is 2 cycles.
- There is always exactly one IDLE bubble cycle between consecutive transactions.
- All RAM-side outputs are registered-state decodes. None depend combinationally on cache request inputs.
- Wait outputs depend combinationally on ramstate.
- Reset mid-transaction:
  - Immediate return to reset values.
  - The in-flight RAM strobe drops asynchronously and no completion pulse is issued.
- Simultaneous iREN and dWEN from IDLE with dstreak<MAX_DSTREAK: data wins.

## Test plan
- Reset, then single read: iREN=1, iaddr=0x40; ramstate=ACCESS on the 1st busy cycle with ramload=0xDEADBEEF → ramREN=1 and ramaddr=0x40 in cycle 1; iwait=0 and iload=0xDEADBEEF in cycle 1; IDLE in cycle 2.
- Write with dREN=dWEN=1, daddr=0x80, dstore=0x1234; change daddr/dstore to 0 after grant; ramstate BUSY for 2 cycles, then ACCESS → ramWEN=1, ramREN=0, ramaddr=0x80, ramstore=0x1234 held throughout; dwait=0 only on the ACCESS cycle.
- iREN and dREN held high continuously, every access completing on its first busy cycle → grant order D,D,D,D,I,D,D,D,D,I with MAX_DSTREAK=4.
- ERROR response once, then ACCESS, on a data read → iwait/dwait stay high through the ERROR; return to IDLE; re-grant; err_count=1; dwait=0 on the retry's ACCESS cycle.
- nRST asserted while in DBUSY with ramWEN=1 → ramWEN=0 immediately; dwait=1; err_count=0; state IDLE; a new iREN after release is granted normally.
- 300 consecutive ERROR responses → err_count saturates at 255, no wraparound.
